// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU control encodings and issue FSM states shared by the ALU issue controller
package alu_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps a 3-bit opcode to the ALU control word plus legal/arithmetic qualifiers
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [3:0] ctrl,
  output logic       legal,
  output logic       is_arith
);
  assign ctrl = op == OP_OR   ? CTRL_OR   :
                op == OP_ADD  ? CTRL_ADD  :
                op == OP_SUB  ? CTRL_SUB  :
                op == OP_SLT  ? CTRL_SLT  :
                op == OP_NOR  ? CTRL_NOR  :
                op == OP_NAND ? CTRL_NAND : CTRL_AND;
  assign legal = op != OP_ILL;
  assign is_arith = op == OP_ADD || op == OP_SUB;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues requests to a registered 32-bit ALU and returns a held response with sticky overflow and op counter
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic             rsp_err,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);
  state_t     state;
  logic [3:0] dec_ctrl;
  logic       dec_legal;
  logic       dec_arith;
  logic       arith_q;
  alu_op_decode u_dec (
    .op       (req_op),
    .ctrl     (dec_ctrl),
    .legal    (dec_legal),
    .is_arith (dec_arith)
  );
  assign req_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctrl     <= CTRL_AND;
      arith_q      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      sticky_ovf   <= 1'b0;
      op_count     <= '0;
    end else begin
      sticky_ovf <= (state == CAPT && arith_q && alu_overflow) || (sticky_ovf && !clr_sticky);
      case (state)
        IDLE: if (req_valid) begin
          if (dec_legal) begin
            alu_src1 <= req_a;
            alu_src2 <= req_b;
            alu_ctrl <= dec_ctrl;
            arith_q  <= dec_arith;
            state    <= EXEC;
          end else begin
            rsp_result   <= '0;
            rsp_zero     <= 1'b1;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_cout     <= arith_q && alu_cout;
          rsp_overflow <= arith_q && alu_overflow;
          rsp_err      <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + CNT_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream sequencing stage for the 32-bit registered ALU. It accepts operation requests over a valid/ready handshake and decodes a 3-bit opcode into the ALU's 4-bit control word (bit3 A_invert, bit2 B_invert/cin, bits1:0 operation). It drives the ALU operands, waits out the ALU's one-cycle registered latency, then captures result and flags into a held response with its own valid/ready handshake. It also keeps a sticky overflow flag and a completed-operation counter for the core's status logic.

Parameters:
CNT_W, 16, width of completed-operation counter (wraps)

Ports:
clk  input  1  system clock
rst_n  input  1  negative reset
req_valid  input  1  request present
req_ready  output  1  block can accept request
req_op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 NAND, 111 illegal
req_a  input  32  operand A
req_b  input  32  operand B
alu_src1  output  32  registered operand to ALU src1
alu_src2  output  32  registered operand to ALU src2
alu_ctrl  output  4  registered ALU_control
alu_result  input  32  ALU registered result
alu_zero  input  1  ALU registered zero
alu_cout  input  1  ALU registered carry out
alu_overflow  input  1  ALU registered overflow
rsp_valid  output  1  response held
rsp_ready  input  1  consumer takes response
rsp_result  output  32  captured result
rsp_zero  output  1  captured zero
rsp_cout  output  1  captured carry (ADD/SUB only, else 0)
rsp_overflow  output  1  captured overflow (ADD/SUB only, else 0)
rsp_err  output  1  illegal opcode
clr_sticky  input  1  clear sticky overflow
sticky_ovf  output  1  sticky overflow status
op_count  output  CNT_W  responses completed

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n). rst_n low -> state IDLE; alu_src1/alu_src2/rsp_result = 0; alu_ctrl = 4'b0000; rsp_valid, rsp_zero, rsp_cout, rsp_overflow, rsp_err, sticky_ovf = 0; op_count = 0. Reset mid-operation abandons the operation; no response is produced.
- Decode: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NAND 1101.
- FSM IDLE -> EXEC -> CAPT -> RESP -> IDLE. req_ready = 1 only in IDLE.
- IDLE: on req_valid & req_ready, register req_a/req_b into alu_src1/2 and the decoded word into alu_ctrl; next state EXEC. Illegal opcode: ALU registers are untouched; rsp_result = 0, rsp_zero = 1, rsp_cout = rsp_overflow = 0, rsp_err = 1, rsp_valid = 1; next state RESP.
- EXEC: ALU samples its operands at the end of this cycle; next state CAPT.
- CAPT: capture alu_result/alu_zero into rsp regs. rsp_cout/rsp_overflow take the ALU values only if the op is ADD or SUB, else 0. rsp_err = 0, rsp_valid = 1; next state RESP.
- Latency: request accepted at edge k -> rsp_valid high after edge k+3 for legal ops, k+1 for illegal.
- RESP: hold all rsp_* stable while rsp_ready is low. On rsp_ready, rsp_valid = 0, op_count += 1 (wraps at 2^CNT_W-1 -> 0), next state IDLE. The next request is accepted no earlier than the following cycle.
- alu_src1/2 and alu_ctrl hold their last values between operations.
- sticky_ovf: set on the CAPT edge when the captured rsp_overflow = 1; cleared by clr_sticky. If set and clear occur together, set wins.
- req_* are ignored outside IDLE. rsp_ready is ignored outside RESP.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_AND..OP_ILL), ALU_control encodings (CTRL_AND=4'b0000 ... CTRL_NAND=4'b1101), FSM state encoding.
- One combinational sub-module alu_op_decode: req_op -> {ctrl[3:0], legal, is_arith}.
- Bench instantiates alu_issue_ctrl wired to the real ALU.

Test Plan:
- ADD a=32'h7FFFFFFF, b=1, rsp_ready=1 -> rsp_valid 3 edges after accept; result 32'h80000000, overflow=1, cout=0, zero=0, sticky_ovf=1, op_count=1.
- SUB a=5, b=5 -> result 0, zero=1, cout=1, overflow=0, err=0, alu_ctrl=4'b0110 during EXEC.
- SLT a=32'hFFFFFFFF (-1), b=1 -> result 1. Then AND a=32'hF0F0F0F0, b=32'hFF00FF00 -> result 32'hF000F000, cout=0, overflow=0.
- Illegal op 111 -> rsp_valid after 1 edge, rsp_err=1, result 0, zero=1; alu_ctrl unchanged. Hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0, new req_valid ignored.
- clr_sticky asserted on the same edge as an overflowing ADD capture -> sticky_ovf=1. clr_sticky alone next cycle -> sticky_ovf=0.
- rst_n dropped during EXEC -> outputs reset immediately, no rsp_valid after release, op_count=0. Also: 2^CNT_W completed ops -> op_count wraps to 0.
